uart_byte_tx: RTL and testbench

UART_BYTE_TX -- requirements
Module: uart_byte_tx

---
 rtl/uart_byte_tx.sv | 138 +++++++++++++
 tb/tb_uart_byte_tx.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_tx.sv
// Byte-wide UART transmitter: LSB-first frame with optional parity and 1 or 2 stop bits.
// One frame in flight; requests that arrive while busy are dropped and flagged.
module uart_byte_tx #(
  parameter int BAUD_DIV  = 434,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] write_data,
  input  logic       write_en,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       overrun
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic        PAR_ODD   = (PARITY == 1);
  localparam logic        PAR_EN    = (PARITY != 0);

  state_t      state_reg, state_next;
  logic [15:0] baud_reg, baud_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  shift_reg, shift_next;
  logic        parity_reg, parity_next;
  logic        tx_reg, tx_next;
  logic        done_reg, done_next;
  logic        overrun_reg, overrun_next;
  logic        baud_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      baud_reg    <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      tx_reg      <= 1'b1;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      tx_reg      <= tx_next;
      done_reg    <= done_next;
      overrun_reg <= overrun_next;
    end
  end

  assign baud_end = (baud_reg == BAUD_LAST);

  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_next     = bit_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    done_next    = 1'b0;
    overrun_next = 1'b0;

    if (state_reg != ST_IDLE) begin
      overrun_next = write_en;
      baud_next    = baud_end ? 16'd0 : baud_reg + 16'd1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (write_en) begin
          state_next  = ST_START;
          shift_next  = write_data;
          parity_next = (^write_data) ^ PAR_ODD;
          baud_next   = '0;
          bit_next    = '0;
        end
      end
      ST_START: begin
        if (baud_end) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (baud_end) begin
          shift_next = {1'b0, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
            bit_next   = '0;
            state_next = PAR_EN ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (baud_end) state_next = ST_STOP;
      end
      ST_STOP: begin
        // bit_reg counts stop bits so two-stop frames reuse the same baud timer
        if (baud_end) begin
          if (bit_reg == STOP_LAST) begin
            state_next = ST_IDLE;
            bit_next   = '0;
            done_next  = 1'b1;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        baud_next  = '0;
        bit_next   = '0;
      end
    endcase

    // Line level is derived from the upcoming state so tx stays a clean flop output
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
      ST_PARITY: tx_next = parity_reg;
      default:   tx_next = 1'b1;
    endcase
  end

  assign tx      = tx_reg;
  assign tx_busy = (state_reg != ST_IDLE);
  assign tx_done = done_reg;
  assign overrun = overrun_reg;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: four instances (8N1, 8E1, 8O1, 8N2) at BAUD_DIV=4,
// each watched by a line receiver that checks frames against a scoreboard queue.
module tb_uart_byte_tx;

  localparam int BD = 4;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         busy_len;
  } exp_t;

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       par;
    int         busy_len;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] we;
  logic [7:0] wd [4];
  logic [3:0] tx, busy, done, ovr;

  exp_t exp_q [4][$];
  int   checks = 0;
  int   errors = 0;
  int   sends [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h", name, inst, act, expv);
    end
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int PAR_G = (gi == 1) ? 2 : (gi == 2) ? 1 : 0;
    localparam int SB_G  = (gi == 3) ? 2 : 1;

    int frames_ok = 0;
    int done_cnt  = 0;
    int ovr_cnt   = 0;

    uart_byte_tx #(.BAUD_DIV(BD), .PARITY(PAR_G), .STOP_BITS(SB_G)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .write_data(wd[gi]),
      .write_en  (we[gi]),
      .tx        (tx[gi]),
      .tx_busy   (busy[gi]),
      .tx_done   (done[gi]),
      .overrun   (ovr[gi])
    );

    initial forever begin
      @(negedge clk);
      if (done[gi] === 1'b1) done_cnt++;
      if (ovr[gi] === 1'b1) ovr_cnt++;
    end

    // Receiver: record every line cycle of a frame, then compare to the queued byte
    initial begin : mon
      logic       smp [0:127];
      int         n, bad, k;
      bit         aborted;
      logic       bitval;
      logic [7:0] rx;
      exp_t       e;
      forever begin
        @(negedge clk);
        if (reset !== 1'b0 || tx[gi] !== 1'b0) continue;
        n = 0;
        aborted = 0;
        while (busy[gi] === 1'b1 && n < 128) begin
          smp[n] = tx[gi];
          n++;
          @(negedge clk);
          if (reset === 1'b1) begin
            aborted = 1;
            break;
          end
        end
        if (exp_q[gi].size() == 0) begin
          chk("unexpected_frame", gi, 1, 0);
          continue;
        end
        e = exp_q[gi].pop_front();
        if (aborted) continue;
        chk("busy_len", gi, n, e.busy_len);
        chk("done_at_end", gi, done[gi], 1);
        chk("idle_tx", gi, tx[gi], 1);
        bad = 0;
        for (int c = 0; c < e.busy_len; c++) begin
          k = c / BD;
          if (k == 0)                      bitval = 1'b0;
          else if (k <= 8)                 bitval = e.data[k-1];
          else if (PAR_G != 0 && k == 9)   bitval = e.par;
          else                             bitval = 1'b1;
          if (c >= n || smp[c] !== bitval) bad++;
        end
        chk("line_cycles", gi, bad, 0);
        rx = '0;
        for (int b = 0; b < 8; b++)
          if ((b + 1) * BD + BD / 2 < n) rx[b] = smp[(b + 1) * BD + BD / 2];
        chk("rx_data", gi, rx, e.data);
        if (PAR_G != 0 && 9 * BD + BD / 2 < n)
          chk("parity_bit", gi, smp[9 * BD + BD / 2], e.par);
        frames_ok++;
      end
    end
  end

  task automatic push(int inst, logic [7:0] d, logic p, int len);
    exp_t e;
    e.data = d;
    e.par = p;
    e.busy_len = len;
    exp_q[inst].push_back(e);
    sends[inst]++;
  endtask

  task automatic wait_idle(int inst);
    int t;
    t = 0;
    while (busy[inst] !== 1'b0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 200) chk("idle_timeout", inst, 1, 0);
  endtask

  task automatic send(int inst, logic [7:0] d, logic p, int len);
    wait_idle(inst);
    we[inst] = 1'b1;
    wd[inst] = d;
    push(inst, d, p, len);
    @(posedge clk);
    #1;
    we[inst] = 1'b0;
    wd[inst] = ~d;
  endtask

  task automatic end_chk(int inst, int frames, int dones, int ovrs, int exp_frames, int exp_ovr);
    chk("frames_decoded", inst, frames, exp_frames);
    chk("done_pulses", inst, dones, exp_frames);
    chk("overrun_pulses", inst, ovrs, exp_ovr);
    chk("queue_empty", inst, exp_q[inst].size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    vec_t       tbl [12];
    logic [7:0] b2b [14];
    int         t;

    tbl = '{
      '{0, 8'hA5, 1'b0, 40},
      '{1, 8'h07, 1'b1, 44},
      '{2, 8'h07, 1'b0, 44},
      '{3, 8'hFF, 1'b0, 44},
      '{1, 8'h00, 1'b0, 44},
      '{2, 8'h00, 1'b1, 44},
      '{1, 8'h81, 1'b0, 44},
      '{2, 8'h81, 1'b1, 44},
      '{0, 8'h00, 1'b0, 40},
      '{3, 8'h3C, 1'b0, 44},
      '{1, 8'h80, 1'b1, 44},
      '{2, 8'hFE, 1'b0, 44}
    };
    b2b = '{8'hFF, 8'hFF, 8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F,
            8'h2C, 8'h20, 8'h55, 8'h41, 8'h52, 8'h0D, 8'h0A};

    reset = 1'b1;
    we = '0;
    for (int i = 0; i < 4; i++) wd[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", 0, tx, 4'hF);
    chk("reset_busy", 0, busy, 4'h0);
    chk("reset_done", 0, done, 4'h0);
    chk("reset_overrun", 0, ovr, 4'h0);

    // Requests coincident with reset must be lost
    we = 4'hF;
    @(posedge clk);
    #1;
    we = '0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_drops_we", 0, busy, 4'h0);
    chk("reset_drops_we_tx", 0, tx, 4'hF);

    for (int i = 0; i < 12; i++)
      send(tbl[i].inst, tbl[i].data, tbl[i].par, tbl[i].busy_len);
    for (int i = 0; i < 4; i++) wait_idle(i);

    // Second request at cycle 10 of a frame: overrun on cycle 11, line keeps 8'h55
    we[0] = 1'b1;
    wd[0] = 8'h55;
    push(0, 8'h55, 1'b0, 40);
    @(posedge clk);
    #1;
    we[0] = 1'b0;
    wd[0] = 8'h00;
    repeat (9) @(posedge clk);
    #1;
    chk("overrun_quiet", 0, ovr[0], 0);
    we[0] = 1'b1;
    wd[0] = 8'h12;
    @(posedge clk);
    #1;
    chk("overrun_c11", 0, ovr[0], 1);
    chk("overrun_busy", 0, busy[0], 1);
    we[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("overrun_one_cycle", 0, ovr[0], 0);
    wait_idle(0);

    // Request held two cycles from idle: first accepted, second flagged
    wait_idle(2);
    we[2] = 1'b1;
    wd[2] = 8'h5A;
    push(2, 8'h5A, 1'b1, 44);
    @(posedge clk);
    #1;
    chk("consec_busy", 2, busy[2], 1);
    chk("consec_tx_start", 2, tx[2], 0);
    chk("consec_no_ovr_yet", 2, ovr[2], 0);
    wd[2] = 8'hC6;
    @(posedge clk);
    #1;
    chk("consec_overrun", 2, ovr[2], 1);
    we[2] = 1'b0;
    wait_idle(2);

    // Back-to-back stream: each new byte issued in the tx_done cycle
    send(0, b2b[0], 1'b0, 40);
    for (int i = 1; i < 14; i++) begin
      t = 0;
      @(negedge clk);
      while (done[0] !== 1'b1 && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk("b2b_done_timeout", 0, 1, 0);
      we[0] = 1'b1;
      wd[0] = b2b[i];
      push(0, b2b[i], 1'b0, 40);
      @(posedge clk);
      #1;
      we[0] = 1'b0;
      wd[0] = ~b2b[i];
      chk("b2b_restart", 0, {busy[0], tx[0]}, 2'b10);
    end
    wait_idle(0);

    // Reset during cycle 20 of a frame aborts it without tx_done
    send(0, 8'hC3, 1'b0, 40);
    repeat (19) @(posedge clk);
    #1;
    chk("abort_midframe", 0, busy[0], 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_tx", 0, tx[0], 1);
    chk("abort_busy", 0, busy[0], 0);
    chk("abort_no_done", 0, done[0], 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_no_done_later", 0, done[0], 0);
    send(0, 8'h96, 1'b0, 40);

    for (int i = 0; i < 4; i++) wait_idle(i);
    repeat (3) @(posedge clk);
    #1;

    end_chk(0, g_dut[0].frames_ok, g_dut[0].done_cnt, g_dut[0].ovr_cnt, sends[0] - 1, 1);
    end_chk(1, g_dut[1].frames_ok, g_dut[1].done_cnt, g_dut[1].ovr_cnt, sends[1], 0);
    end_chk(2, g_dut[2].frames_ok, g_dut[2].done_cnt, g_dut[2].ovr_cnt, sends[2], 1);
    end_chk(3, g_dut[3].frames_ok, g_dut[3].done_cnt, g_dut[3].ovr_cnt, sends[3], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
